loop_mem_responder: RTL
=======================

Name: loop_mem_responder

Overview:
- Memory-side responder for the loop recorder's per-clock SDRAM request stream: address, writedata, write enable and an expected readdata word every clk.
- Buffers each request in a command FIFO and replays it as an Avalon-MM master transaction (waitrequest, pipelined reads with readdatavalid) toward the SDRAM controller.
- Read returns land in an 8-entry slot bank indexed by address[2:0], matching the recorder's 8-phase left/right × 4-loop slot counter.
- The bank drives readdata back to the recorder.

Parameters:
- CMD_DEPTH, 16, command FIFO entries (power of two, ≥4).
- MAX_OUTSTANDING, 8, maximum reads issued but not yet returned (1..8).
- ADDR_W, 25, address width.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous active-low reset
- req_valid  in  1  request present this cycle (recorder ties high)
- req_address  in  ADDR_W  request word address; [2:0] = slot
- req_write_en  in  1  1 = write request, 0 = read request
- req_writedata  in  32  write data
- readdata  out  32  slot-bank word for the current request's slot
- avm_address  out  ADDR_W  Avalon address
- avm_read  out  1  Avalon read strobe
- avm_write  out  1  Avalon write strobe
- avm_writedata  out  32  Avalon write data
- avm_waitrequest  in  1  controller stall
- avm_readdata  in  32  returned read data
- avm_readdatavalid  in  1  return strobe
- overflow  out  1  sticky: a request was dropped
- drop_count  out  16  dropped-request count (see Optional Feature)

Behaviour:
- Reset (async, reset=0): FIFOs emptied; outstanding=0; all bank entries 0; FSM=IDLE.
  - All outputs 0: readdata, avm_read, avm_write, avm_address, avm_writedata, overflow, drop_count.
- Push: on each clk with req_valid=1, {req_write_en, req_address, req_writedata} enters the command FIFO.
  - If the FIFO is full that cycle (after any same-cycle pop), the request is dropped and overflow is set.
  - overflow clears only on reset.
- Simultaneous push and pop on a full FIFO: the pop frees a slot, so the push succeeds.
- Issue FSM:
  - IDLE:
    - Stay while the FIFO is empty, or the head is a read and outstanding == MAX_OUTSTANDING.
    - Otherwise move to ISSUE next cycle.
  - ISSUE:
    - Drive the head onto avm_address/avm_writedata, with avm_write = write_en and avm_read = !write_en.
    - Hold all Avalon outputs stable while avm_waitrequest=1.
    - On a cycle with avm_waitrequest=0 the command is accepted: pop the FIFO.
    - For a read, push address[2:0] into the tag FIFO (depth MAX_OUTSTANDING) and increment outstanding.
    - Then stay in ISSUE if the next head is issuable, else go to IDLE.
    - avm_read/avm_write are 0 in IDLE.
  - Back-to-back accepted commands are allowed (one per clk).
- Read return: on avm_readdatavalid=1, bank[tag_head] ← avm_readdata, pop the tag FIFO, decrement outstanding.
  - Same-cycle accept and return: outstanding is unchanged.
  - readdatavalid with the tag FIFO empty (e.g. late return after reset) is ignored.
- readdata: registered. One clk after request cycle N, it equals bank[req_address[2:0] of cycle N].
  - Bypass: if a return writes that same slot in cycle N, readdata shows the new avm_readdata.
- Writes never modify the bank.
- Command order is preserved; reads and writes are not reordered.
- End-to-end read latency:
  - 1 clk FIFO, +1 clk IDLE→ISSUE if idle, + waitrequest cycles, + controller latency, + 1 clk bank-to-readdata.
- Address wrap is the recorder's responsibility; the block passes addresses unmodified.

Optional Feature:
- Macro LOOP_MEM_DROP_CNT_EN.
- Defined: drop_count increments on each dropped request and saturates at 16'hFFFF; reset to 0.
- Undefined: no counter logic; drop_count tied to 0; overflow still implemented.

Test Plan:
- Reset, idle: reset=0 then 1, req_valid=0 for 10 clk → all Avalon strobes 0, readdata=0, overflow=0.
- Single write: addr 0x000010, data 0xDEADBEEF, write_en=1, waitrequest=0.
  - Expect avm_write=1 with the same addr/data exactly once, within 2 clk.
  - readdata stays 0.
- Read return to slot:
  - Read addr 0x000013; controller returns 0x12345678 with readdatavalid 3 clk after accept.
  - A later request with address[2:0]=3 → readdata=0x12345678 one clk later.
  - Other slots remain 0.
- Waitrequest stall: waitrequest=1 for 5 clk during a read of addr 0x20 → avm_address/avm_read stable for all 5 clk; single acceptance; FIFO pop only after release.
- Overflow: waitrequest held 1, 20 consecutive writes with CMD_DEPTH=16.
  - overflow=1 and the last 4 requests are dropped.
  - With LOOP_MEM_DROP_CNT_EN, drop_count=4; without it, drop_count=0.
  - On release, exactly 16 writes appear in order.
- Outstanding limit and reset mid-op:
  - 10 reads with returns withheld → exactly 8 accepted, then avm_read=0.
  - Assert reset, release, deliver 2 stale readdatavalid → bank stays 0.

Source files
------------

// File: rtl/loop_mem_responder.sv
// Memory-side responder: queues recorder requests, replays them as Avalon-MM commands and
// keeps an 8-slot bank of read returns. Macro LOOP_MEM_DROP_CNT_EN enables the drop counter.
module loop_mem_responder #(
    parameter int CMD_DEPTH       = 16,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ADDR_W          = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_address,
    input  logic              req_write_en,
    input  logic [31:0]       req_writedata,
    output logic [31:0]       readdata,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              overflow,
    output logic [15:0]       drop_count
);
    localparam int CW = $clog2(CMD_DEPTH);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW:0]   CNT_FULL = (CW+1)'(CMD_DEPTH);
    localparam logic [CW:0]   CNT_ONE  = (CW+1)'(1);
    localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTSTANDING - 1);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } cmd_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    cmd_t              cmd_mem [CMD_DEPTH];
    logic [CW-1:0]     wr_ptr_q, rd_ptr_q, nxt_ptr;
    logic [CW:0]       cnt_q;
    logic [2:0]        tag_mem [MAX_OUTSTANDING];
    logic [TW-1:0]     tag_wr_q, tag_rd_q;
    logic [OW-1:0]     out_q, out_d;
    logic [7:0][31:0]  bank_q;
    logic [31:0]       readdata_q;
    logic              overflow_q;
    state_t            state_q;
    logic [ADDR_W-1:0] avm_address_q;
    logic [31:0]       avm_writedata_q;
    logic              avm_read_q, avm_write_q;

    cmd_t       in_cmd, head, nxt;
    logic       accept, acc_rd, push, drop, ret_ok, nxt_vld, head_ok, nxt_ok;
    logic [2:0] slot, tag_head;

    assign in_cmd   = {req_write_en, req_address, req_writedata};
    assign head     = cmd_mem[rd_ptr_q];
    assign nxt_ptr  = rd_ptr_q + 1'b1;
    assign accept   = (state_q == ISSUE) && !avm_waitrequest;
    assign acc_rd   = accept && avm_read_q;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign push     = req_valid && ((cnt_q != CNT_FULL) || accept);
    assign drop     = req_valid && !push;
    assign ret_ok   = avm_readdatavalid && (out_q != '0);
    assign slot     = req_address[2:0];
    assign tag_head = tag_mem[tag_rd_q];

    // Command following the one being accepted; may be the request arriving this cycle.
    assign nxt_vld  = (cnt_q > CNT_ONE) || ((cnt_q == CNT_ONE) && push);
    assign nxt      = (cnt_q > CNT_ONE) ? cmd_mem[nxt_ptr] : in_cmd;
    assign head_ok  = (cnt_q != '0) && (head.we || (out_q < OUT_MAX));
    assign nxt_ok   = nxt_vld && (nxt.we || (out_d < OUT_MAX));

    always_comb begin
        out_d = out_q;
        if (acc_rd && !ret_ok)      out_d = out_q + 1'b1;
        else if (!acc_rd && ret_ok) out_d = out_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)   cmd_mem[wr_ptr_q] <= in_cmd;
        if (acc_rd) tag_mem[tag_wr_q] <= avm_address_q[2:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            out_q      <= '0;
            bank_q     <= '0;
            readdata_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
            if (accept) rd_ptr_q <= nxt_ptr;
            if (push && !accept)      cnt_q <= cnt_q + 1'b1;
            else if (!push && accept) cnt_q <= cnt_q - 1'b1;
            if (acc_rd) tag_wr_q <= (tag_wr_q == TAG_LAST) ? '0 : tag_wr_q + 1'b1;
            if (ret_ok) begin
                tag_rd_q         <= (tag_rd_q == TAG_LAST) ? '0 : tag_rd_q + 1'b1;
                bank_q[tag_head] <= avm_readdata;
            end
            out_q      <= out_d;
            readdata_q <= (ret_ok && (tag_head == slot)) ? avm_readdata : bank_q[slot];
            if (drop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
            avm_read_q      <= 1'b0;
            avm_write_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (head_ok) begin
                    state_q         <= ISSUE;
                    avm_address_q   <= head.addr;
                    avm_writedata_q <= head.data;
                    avm_write_q     <= head.we;
                    avm_read_q      <= !head.we;
                end
                ISSUE: if (!avm_waitrequest) begin
                    if (nxt_ok) begin
                        avm_address_q   <= nxt.addr;
                        avm_writedata_q <= nxt.data;
                        avm_write_q     <= nxt.we;
                        avm_read_q      <= !nxt.we;
                    end else begin
                        state_q     <= IDLE;
                        avm_write_q <= 1'b0;
                        avm_read_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LOOP_MEM_DROP_CNT_EN
    logic [15:0] drop_cnt_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                               drop_cnt_q <= '0;
        else if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif

    assign readdata      = readdata_q;
    assign avm_address   = avm_address_q;
    assign avm_read      = avm_read_q;
    assign avm_write     = avm_write_q;
    assign avm_writedata = avm_writedata_q;
    assign overflow      = overflow_q;

endmodule
